// File: rtl/cache_pkg.sv
// Shared types and address helpers for the set-associative cache.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SWAP_OUT,
    SWAP_IN,
    SWAP_IN_OK
  } cache_state_t;

  localparam logic POL_FIFO = 1'b0;
  localparam logic POL_LRU  = 1'b1;

  function automatic logic [31:0] addr_field(
    input logic [31:0] a,
    input int          lo,
    input int          w
  );
    return (a >> lo) & ((32'h1 << w) - 32'h1);
  endfunction

  function automatic int set_lo(input int line_len);
    return 2 + line_len;
  endfunction

  function automatic int tag_lo(input int line_len, input int set_len);
    return 2 + line_len + set_len;
  endfunction

endpackage

// File: rtl/cache_repl.sv
// Per-set FIFO pointers and LRU ages; both kept live so policy can switch.
module cache_repl
  import cache_pkg::*;
#(
  parameter  int SET_ADDR_LEN = 3,
  parameter  int WAY_CNT      = 4,
  localparam int WW           = $clog2(WAY_CNT),
  localparam int SETS         = 1 << SET_ADDR_LEN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SET_ADDR_LEN-1:0] set,
  input  logic [WW-1:0]           way,
  input  logic                    touch,
  input  logic                    fill,
  output logic [WW-1:0]           fifo_vic,
  output logic [WW-1:0]           lru_vic
);

  logic [WW-1:0] ptr_q [SETS];
  logic [WW-1:0] age_q [SETS][WAY_CNT];

  assign fifo_vic = ptr_q[set];

  always_comb begin
    lru_vic = '0;
    for (int i = 0; i < WAY_CNT; i++)
      if (age_q[set][i] == WW'(WAY_CNT - 1)) lru_vic = WW'(i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        ptr_q[s] <= '0;
        for (int i = 0; i < WAY_CNT; i++)
          age_q[s][i] <= WW'(WAY_CNT - 1 - i);
      end
    end else begin
      if (fill)
        ptr_q[set] <= (ptr_q[set] == WW'(WAY_CNT - 1)) ?
                      '0 : ptr_q[set] + WW'(1);
      // ways younger than the touched one age by one
      if (touch || fill) begin
        for (int i = 0; i < WAY_CNT; i++) begin
          if (WW'(i) == way)
            age_q[set][i] <= '0;
          else if (age_q[set][i] < age_q[set][way])
            age_q[set][i] <= age_q[set][i] + WW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/main_mem.sv
// Slow line-wide backing memory; unwritten lines read as an address pattern.
module main_mem #(
  parameter  int ADDR_LEN      = 10,
  parameter  int LINE_ADDR_LEN = 3,
  parameter  int LATENCY       = 4,
  localparam int WORDS         = 1 << LINE_ADDR_LEN,
  localparam int LINE_W        = 32 * WORDS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd_req,
  input  logic                wr_req,
  input  logic [ADDR_LEN-1:0] addr,
  input  logic [LINE_W-1:0]   wr_line,
  output logic [LINE_W-1:0]   rd_line,
  output logic                gnt
);

  logic [LINE_W-1:0]        mem_q [1 << ADDR_LEN];
  logic [(1<<ADDR_LEN)-1:0] wrote_q;
  logic [7:0]               cnt_q;
  logic [LINE_W-1:0]        cur;
  logic                     done;

  assign done = !gnt && (rd_req || wr_req) && cnt_q == 8'(LATENCY - 1);

  always_comb begin
    for (int w = 0; w < WORDS; w++)
      cur[w*32 +: 32] = 32'hC0DE_0000 ^ 32'({addr, LINE_ADDR_LEN'(w)});
    if (wrote_q[addr]) cur = mem_q[addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      gnt     <= 1'b0;
      rd_line <= '0;
      wrote_q <= '0;
    end else if (gnt) begin
      gnt   <= 1'b0;
      cnt_q <= '0;
    end else if (done) begin
      gnt   <= 1'b1;
      cnt_q <= '0;
      if (wr_req) wrote_q[addr] <= 1'b1;
      else        rd_line       <= cur;
    end else if (rd_req || wr_req) begin
      cnt_q <= cnt_q + 8'd1;
    end else begin
      cnt_q <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (done && wr_req) mem_q[addr] <= wr_line;
  end

endmodule

// File: rtl/assoc_cache.sv
// N-way set-associative write-back, write-allocate cache
// with FIFO/LRU replacement and hit/miss counters.
module assoc_cache
  import cache_pkg::*;
#(
  parameter int LINE_ADDR_LEN = 3,
  parameter int SET_ADDR_LEN  = 3,
  parameter int TAG_ADDR_LEN  = 7,
  parameter int WAY_CNT       = 4,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             policy,
  input  logic [31:0]      addr,
  input  logic             rd_req,
  input  logic             wr_req,
  input  logic [31:0]      wr_data,
  output logic [31:0]      rd_data,
  output logic             miss,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int WW     = $clog2(WAY_CNT);
  localparam int SETS   = 1 << SET_ADDR_LEN;
  localparam int LINE_W = 32 * (1 << LINE_ADDR_LEN);
  localparam int MEM_W  = TAG_ADDR_LEN + SET_ADDR_LEN;

  cache_state_t state_q, state_d;

  logic [LINE_W-1:0]       data_q  [SETS][WAY_CNT];
  logic [TAG_ADDR_LEN-1:0] tag_q   [SETS][WAY_CNT];
  logic [WAY_CNT-1:0]      valid_q [SETS];
  logic [WAY_CNT-1:0]      dirty_q [SETS];

  logic [WW-1:0]           vic_way;
  logic [SET_ADDR_LEN-1:0] vic_set;
  logic [TAG_ADDR_LEN-1:0] req_tag;
  logic [MEM_W-1:0]        wb_addr;
  logic [LINE_W-1:0]       wb_line;

  logic [LINE_ADDR_LEN-1:0] word_a;
  logic [SET_ADDR_LEN-1:0]  set_a;
  logic [TAG_ADDR_LEN-1:0]  tag_a;

  logic          hit, req, idle, acc, take, fill;
  logic [WW-1:0] hit_way, new_vic, fifo_vic, lru_vic;

  logic              mem_rd_req, mem_wr_req, mem_gnt;
  logic [MEM_W-1:0]  mem_addr;
  logic [LINE_W-1:0] mem_rd_line;

  assign word_a = LINE_ADDR_LEN'(addr_field(addr, 2, LINE_ADDR_LEN));
  assign set_a  = SET_ADDR_LEN'(addr_field(addr, set_lo(LINE_ADDR_LEN),
                                           SET_ADDR_LEN));
  assign tag_a  = TAG_ADDR_LEN'(addr_field(addr,
                    tag_lo(LINE_ADDR_LEN, SET_ADDR_LEN), TAG_ADDR_LEN));

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int i = WAY_CNT - 1; i >= 0; i--) begin
      if (valid_q[set_a][i] && tag_q[set_a][i] == tag_a) begin
        hit     = 1'b1;
        hit_way = WW'(i);
      end
    end
  end

  assign req  = rd_req | wr_req;
  assign idle = (state_q == IDLE);
  assign acc  = idle & req & hit;
  assign take = idle & req & ~hit;
  assign fill = (state_q == SWAP_IN_OK);
  assign miss = req & ~(hit & idle) & ~rst;

  assign new_vic = (policy == POL_LRU) ? lru_vic : fifo_vic;

  cache_repl #(
    .SET_ADDR_LEN (SET_ADDR_LEN),
    .WAY_CNT      (WAY_CNT)
  ) u_repl (
    .clk      (clk),
    .rst      (rst),
    .set      (idle ? set_a : vic_set),
    .way      (idle ? hit_way : vic_way),
    .touch    (acc),
    .fill     (fill),
    .fifo_vic (fifo_vic),
    .lru_vic  (lru_vic)
  );

  assign mem_wr_req = (state_q == SWAP_OUT);
  assign mem_rd_req = (state_q == SWAP_IN);
  assign mem_addr   = mem_wr_req ? wb_addr : {req_tag, vic_set};

  main_mem #(
    .ADDR_LEN      (MEM_W),
    .LINE_ADDR_LEN (LINE_ADDR_LEN)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .rd_req  (mem_rd_req),
    .wr_req  (mem_wr_req),
    .addr    (mem_addr),
    .wr_line (wb_line),
    .rd_line (mem_rd_line),
    .gnt     (mem_gnt)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (take)
          state_d = (valid_q[set_a][new_vic] && dirty_q[set_a][new_vic]) ?
                    SWAP_OUT : SWAP_IN;
      SWAP_OUT:   if (mem_gnt) state_d = SWAP_IN;
      SWAP_IN:    if (mem_gnt) state_d = SWAP_IN_OK;
      SWAP_IN_OK: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
      vic_way  <= '0;
      vic_set  <= '0;
      req_tag  <= '0;
      wb_addr  <= '0;
      wb_line  <= '0;
      rd_data  <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (acc) begin
        hit_cnt <= hit_cnt + CNT_W'(1);
        if (wr_req) dirty_q[set_a][hit_way] <= 1'b1;
        else rd_data <= data_q[set_a][hit_way][{word_a, 5'b0} +: 32];
      end
      // victim chosen once here and held for the whole miss
      if (take) begin
        miss_cnt <= miss_cnt + CNT_W'(1);
        vic_way  <= new_vic;
        vic_set  <= set_a;
        req_tag  <= tag_a;
        wb_addr  <= {tag_q[set_a][new_vic], set_a};
        wb_line  <= data_q[set_a][new_vic];
      end
      if (fill) begin
        valid_q[vic_set][vic_way] <= 1'b1;
        dirty_q[vic_set][vic_way] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (acc && wr_req)
      data_q[set_a][hit_way][{word_a, 5'b0} +: 32] <= wr_data;
    if (fill) begin
      data_q[vic_set][vic_way] <= mem_rd_line;
      tag_q[vic_set][vic_way]  <= req_tag;
    end
  end

endmodule
